// File: rtl/tdm_demux8.sv
// tdm_demux8: 1-to-8 TDM demultiplexer with frame-lock FSM,
// atomic frame publish and a saturating alignment-error counter.
module tdm_demux8 #(
  parameter int WIDTH = 1,
  parameter int ERRW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [WIDTH-1:0]   d0,
  output logic [WIDTH-1:0]   d1,
  output logic [WIDTH-1:0]   d2,
  output logic [WIDTH-1:0]   d3,
  output logic [WIDTH-1:0]   d4,
  output logic [WIDTH-1:0]   d5,
  output logic [WIDTH-1:0]   d6,
  output logic [WIDTH-1:0]   d7,
  output logic [7:0]         ch_valid,
  output logic [8*WIDTH-1:0] frame_out,
  output logic               frame_valid,
  output logic               locked,
  output logic [2:0]         slot,
  output logic               sync_err,
  output logic [ERRW-1:0]    err_cnt
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_slot;
  logic [2:0]         w_slot_nxt;
  logic [2:0]         w_wr_slot;
  logic               w_wr;
  logic               w_err;
  logic               w_pub;
  logic [WIDTH-1:0]   r_d [8];
  logic [7:0]         r_ch_valid;
  logic [8*WIDTH-1:0] r_frame;
  logic [8*WIDTH-1:0] w_frame;
  logic               r_fv;
  logic               r_serr;
  logic [ERRW-1:0]    r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_wr_slot   = r_slot;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    w_pub       = 1'b0;
    if (din_valid) begin
      unique case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_wr        = 1'b1;
            w_wr_slot   = 3'd0;
            w_slot_nxt  = 3'd1;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // early sync realigns onto the new frame
            w_wr       = 1'b1;
            w_wr_slot  = 3'd0;
            w_slot_nxt = 3'd1;
            w_err      = (r_slot != 3'd0);
          end else if (r_slot == 3'd0) begin
            w_err       = 1'b1;
            w_slot_nxt  = 3'd0;
            w_state_nxt = HUNT;
          end else begin
            w_wr       = 1'b1;
            w_slot_nxt = r_slot + 3'd1;
            w_pub      = (r_slot == 3'd7);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // slot 7 comes straight from din so the frame is whole this edge
  assign w_frame = {din, r_d[6], r_d[5], r_d[4],
                    r_d[3], r_d[2], r_d[1], r_d[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_slot     <= 3'd0;
      r_ch_valid <= '0;
      r_frame    <= '0;
      r_fv       <= 1'b0;
      r_serr     <= 1'b0;
      r_cnt      <= '0;
      for (int i = 0; i < 8; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_ch_valid <= w_wr ? (8'b1 << w_wr_slot) : 8'b0;
      r_fv       <= w_pub;
      r_serr     <= w_err;
      if (w_wr) begin
        r_d[w_wr_slot] <= din;
      end
      if (w_pub) begin
        r_frame <= w_frame;
      end
      if (w_err && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign d0          = r_d[0];
  assign d1          = r_d[1];
  assign d2          = r_d[2];
  assign d3          = r_d[3];
  assign d4          = r_d[4];
  assign d5          = r_d[5];
  assign d6          = r_d[6];
  assign d7          = r_d[7];
  assign ch_valid    = r_ch_valid;
  assign frame_out   = r_frame;
  assign frame_valid = r_fv;
  assign locked      = (r_state == LOCKED);
  assign slot        = r_slot;
  assign sync_err    = r_serr;
  assign err_cnt     = r_cnt;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed vectors for tdm_demux8 (WIDTH=4,
// ERRW=2) with hand-computed expected values.
module tb_tdm_demux8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  din;
  logic        din_valid;
  logic        frame_sync;
  logic [3:0]  d [8];
  logic [7:0]  ch_valid;
  logic [31:0] frame_out;
  logic        frame_valid;
  logic        locked;
  logic [2:0]  slot;
  logic        sync_err;
  logic [1:0]  err_cnt;

  int n_vec;
  int n_err;

  tdm_demux8 #(
    .WIDTH(4),
    .ERRW (2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .d0         (d[0]),
    .d1         (d[1]),
    .d2         (d[2]),
    .d3         (d[3]),
    .d4         (d[4]),
    .d5         (d[5]),
    .d6         (d[6]),
    .d7         (d[7]),
    .ch_valid   (ch_valid),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .locked     (locked),
    .slot       (slot),
    .sync_err   (sync_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one accepted sample; outputs are sampled 1ns after the edge
  task automatic send(input logic [3:0] v, input logic s);
    @(negedge clk);
    din        = v;
    din_valid  = 1'b1;
    frame_sync = s;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input int n, input logic [2:0] exp_slot);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = ~frame_sync;
      din        = 4'(k + 9);
      @(posedge clk);
      #1;
      check("gap_chv", 32'(ch_valid), 32'h0);
      check("gap_fv", 32'(frame_valid), 32'h0);
      check("gap_serr", 32'(sync_err), 32'h0);
      check("gap_slot", 32'(slot), 32'(exp_slot));
    end
    frame_sync = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_slot", 32'(slot), 32'h0);
    check("rst_errcnt", 32'(err_cnt), 32'h0);
    check("rst_frame", frame_out, 32'h0);
    check("rst_chv", 32'(ch_valid), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_serr", 32'(sync_err), 32'h0);
    check("rst_d0", 32'(d[0]), 32'h0);
    rst_n = 1'b1;

    // back-to-back frame 0..7
    for (int i = 0; i < 8; i++) begin
      send(4'(i), i == 0);
      check("b2b_chv", 32'(ch_valid), 32'h1 << i);
      check("b2b_d", 32'(d[i]), 32'(i));
      check("b2b_fv", 32'(frame_valid), 32'(i == 7));
    end
    check("b2b_frame", frame_out, 32'h76543210);
    check("b2b_locked", 32'(locked), 32'h1);
    check("b2b_errcnt", 32'(err_cnt), 32'h0);
    check("b2b_slot", 32'(slot), 32'h0);

    // unsynced samples in HUNT are dropped
    do_reset();
    send(4'hA, 1'b0);
    check("hunt_chv_a", 32'(ch_valid), 32'h0);
    check("hunt_serr_a", 32'(sync_err), 32'h0);
    send(4'hB, 1'b0);
    check("hunt_chv_b", 32'(ch_valid), 32'h0);
    check("hunt_lock_b", 32'(locked), 32'h0);
    send(4'h1, 1'b1);
    check("hunt_lock", 32'(locked), 32'h1);
    check("hunt_d0", 32'(d[0]), 32'h1);
    check("hunt_chv", 32'(ch_valid), 32'h1);

    // early sync at slot 4
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    check("pre_early_slot", 32'(slot), 32'h4);
    send(4'hC, 1'b1);
    check("early_serr", 32'(sync_err), 32'h1);
    check("early_errcnt", 32'(err_cnt), 32'h1);
    check("early_d0", 32'(d[0]), 32'hC);
    check("early_slot", 32'(slot), 32'h1);
    check("early_chv", 32'(ch_valid), 32'h1);
    check("early_fv", 32'(frame_valid), 32'h0);
    check("early_lock", 32'(locked), 32'h1);
    check("early_frame", frame_out, 32'h0);
    for (int i = 1; i < 8; i++) begin
      send(4'(i + 8), 1'b0);
      check("post_fv", 32'(frame_valid), 32'(i == 7));
      check("post_serr", 32'(sync_err), 32'h0);
    end
    check("post_frame", frame_out, 32'hFEDCBA9C);

    // missing sync at slot 0
    send(4'h5, 1'b0);
    check("miss_serr", 32'(sync_err), 32'h1);
    check("miss_lock", 32'(locked), 32'h0);
    check("miss_chv", 32'(ch_valid), 32'h0);
    check("miss_d0", 32'(d[0]), 32'hC);
    check("miss_errcnt", 32'(err_cnt), 32'h2);
    check("miss_slot", 32'(slot), 32'h0);

    // relock, then a frame with gaps and toggled sync
    send(4'h0, 1'b1);
    check("relock", 32'(locked), 32'h1);
    check("relock_serr", 32'(sync_err), 32'h0);
    for (int i = 1; i < 8; i++) begin
      idle(1 + (i % 3), 3'(i));
      send(4'(i), 1'b0);
      check("gap_chv_s", 32'(ch_valid), 32'h1 << i);
      check("gap_d", 32'(d[i]), 32'(i));
      check("gap_fv_s", 32'(frame_valid), 32'(i == 7));
    end
    check("gap_frame", frame_out, 32'h76543210);
    check("gap_errcnt", 32'(err_cnt), 32'h2);
    check("gap_lock", 32'(locked), 32'h1);

    // reset mid-frame after slot 5
    for (int i = 0; i < 6; i++) begin
      send(4'(i + 2), i == 0);
    end
    check("mid_slot", 32'(slot), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_lock", 32'(locked), 32'h0);
    check("mr_slot", 32'(slot), 32'h0);
    check("mr_errcnt", 32'(err_cnt), 32'h0);
    check("mr_frame", frame_out, 32'h0);
    check("mr_d5", 32'(d[5]), 32'h0);
    check("mr_d1", 32'(d[1]), 32'h0);
    check("mr_chv", 32'(ch_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation: 5 early syncs with ERRW=2
    send(4'h3, 1'b1);
    check("sat_lock", 32'(locked), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      send(4'h2, 1'b0);
      send(4'(k), 1'b1);
      check("sat_serr", 32'(sync_err), 32'h1);
      check("sat_errcnt", 32'(err_cnt), (k > 3) ? 32'h3 : 32'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
